// File: rtl/param_set_pkg.sv
// Shared types and limits for the streaming SPS/PPS parameter-set decoder.
package param_set_pkg;

    localparam logic [7:0] NAL_SPS = 8'h42;
    localparam logic [7:0] NAL_PPS = 8'h44;

    localparam int NUM_SPS_DEF   = 4;
    localparam int NUM_PPS_DEF   = 8;
    localparam int MAX_WIDTH_DEF = 8192;
    localparam int MAX_UE_LZ_DEF = 16;

    localparam int MAX_CHROMA  = 3;
    localparam int MAX_BD_M8   = 7;
    localparam int MAX_QP      = 51;
    localparam int MAX_TILE_M1 = 14;

    typedef logic [2:0] state_t;
    localparam state_t IDLE      = 3'd0;
    localparam state_t PARSE_SPS = 3'd1;
    localparam state_t PARSE_PPS = 3'd2;
    localparam state_t DRAIN     = 3'd3;
    localparam state_t ERR_DRAIN = 3'd4;
    localparam state_t COMMIT    = 3'd5;
    localparam state_t ERROR     = 3'd6;

    typedef logic [2:0] err_t;
    localparam err_t ERR_NONE  = 3'd0;
    localparam err_t ERR_LZ    = 3'd1;
    localparam err_t ERR_TRUNC = 3'd2;
    localparam err_t ERR_ID    = 3'd3;
    localparam err_t ERR_RANGE = 3'd4;

    typedef enum logic [1:0] {K_NONE, K_SPS, K_PPS} kind_t;

    typedef struct packed {
        logic [7:0]  profile;
        logic [15:0] width;
        logic [15:0] height;
        logic [7:0]  fps;
        logic [1:0]  chroma;
        logic [2:0]  bd_m8;
    } sps_entry_t;

    // tile counts are stored already incremented (1 when tiles are off)
    typedef struct packed {
        logic [7:0] sps_id;
        logic [5:0] qp;
        logic       tiles;
        logic [3:0] cols;
        logic [3:0] rows;
    } pps_entry_t;

endpackage

// File: rtl/param_set_decoder_if.sv
// NAL byte-stream handshake between a producer and the parameter-set decoder.
interface param_set_decoder_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       s_last;

    modport master (output s_data, s_valid, s_last, input s_ready);
    modport slave  (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/param_set_decoder_exp_golomb_reader.sv
// Bit-serial MSB-first reader: one bit per clock, ue(v) or u(n) fields.
module exp_golomb_reader #(
    parameter int MAX_UE_LZ = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        mode_u_i,
    input  logic [3:0]  nbits_i,
    input  logic [7:0]  byte_i,
    input  logic        load_i,
    input  logic        last_seen_i,
    output logic        empty_o,
    output logic        field_valid_o,
    output logic [31:0] value_o,
    output logic        lz_overflow_o,
    output logic        truncated_o
);
    logic [7:0]  buf_q, buf_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        info_q, info_d;
    logic [4:0]  lz_q, lz_d;
    logic [4:0]  n_q, n_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] acc_n;
    logic [4:0]  n_inc;
    logic        bit_c;

    assign empty_o     = (cnt_q == 4'd0);
    assign truncated_o = en_i && empty_o && last_seen_i;

    always_comb begin
        buf_d         = buf_q;
        cnt_d         = cnt_q;
        info_d        = info_q;
        lz_d          = lz_q;
        n_d           = n_q;
        acc_d         = acc_q;
        field_valid_o = 1'b0;
        value_o       = '0;
        lz_overflow_o = 1'b0;
        bit_c         = buf_q[7];
        acc_n         = {acc_q[30:0], bit_c};
        n_inc         = n_q + 5'd1;
        if (load_i) begin
            buf_d = byte_i;
            cnt_d = 4'd8;
        end else if (en_i && !empty_o) begin
            buf_d = {buf_q[6:0], 1'b0};
            cnt_d = cnt_q - 4'd1;
            if (mode_u_i) begin
                if (n_inc == {1'b0, nbits_i}) begin
                    field_valid_o = 1'b1;
                    value_o       = acc_n;
                    acc_d         = '0;
                    n_d           = '0;
                end else begin
                    acc_d = acc_n;
                    n_d   = n_inc;
                end
            end else if (!info_q) begin
                if (!bit_c) begin
                    if (lz_q == 5'(MAX_UE_LZ)) lz_overflow_o = 1'b1;
                    else lz_d = lz_q + 5'd1;
                end else if (lz_q == 5'd0) begin
                    field_valid_o = 1'b1;
                end else begin
                    info_d = 1'b1;
                    n_d    = '0;
                    acc_d  = '0;
                end
            end else if (n_inc == lz_q) begin
                field_valid_o = 1'b1;
                value_o       = ((32'd1 << lz_q) - 32'd1) + acc_n;
                info_d        = 1'b0;
                lz_d          = '0;
                n_d           = '0;
                acc_d         = '0;
            end else begin
                acc_d = acc_n;
                n_d   = n_inc;
            end
        end
        if (clr_i) begin
            cnt_d  = '0;
            info_d = 1'b0;
            lz_d   = '0;
            n_d    = '0;
            acc_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q  <= '0;
            cnt_q  <= '0;
            info_q <= 1'b0;
            lz_q   <= '0;
            n_q    <= '0;
            acc_q  <= '0;
        end else begin
            buf_q  <= buf_d;
            cnt_q  <= cnt_d;
            info_q <= info_d;
            lz_q   <= lz_d;
            n_q    <= n_d;
            acc_q  <= acc_d;
        end
    end
endmodule

// File: rtl/param_set_decoder.sv
// Streaming SPS/PPS parser with ID-indexed tables and activation by PPS ID.
module param_set_decoder
    import param_set_pkg::*;
#(
    parameter int NUM_SPS   = NUM_SPS_DEF,
    parameter int NUM_PPS   = NUM_PPS_DEF,
    parameter int MAX_WIDTH = MAX_WIDTH_DEF,
    parameter int MAX_UE_LZ = MAX_UE_LZ_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    param_set_decoder_if.slave         s,
    input  logic                       act_req,
    input  logic [$clog2(NUM_PPS)-1:0] act_pps_id,
    output logic                       act_ack,
    output logic                       act_error,
    output logic [7:0]                 profile,
    output logic [15:0]                width,
    output logic [15:0]                height,
    output logic [7:0]                 fps,
    output logic [1:0]                 chroma_format,
    output logic [3:0]                 bit_depth,
    output logic [5:0]                 qp,
    output logic                       tiles_enabled,
    output logic [3:0]                 tile_cols,
    output logic [3:0]                 tile_rows,
    output logic                       nal_done,
    output logic                       nal_error,
    output logic [2:0]                 err_code,
    output logic                       busy
);
    localparam int SIDW = $clog2(NUM_SPS);
    localparam int PIDW = $clog2(NUM_PPS);
    localparam int IDW  = (PIDW > SIDW) ? PIDW : SIDW;

    state_t           state_q, state_d;
    logic [2:0]       field_q, field_d;
    kind_t            kind_q, kind_d;
    logic             last_q, last_d;
    err_t             err_q, err_d;
    logic [IDW-1:0]   id_q, id_d;
    sps_entry_t       sh_sps_q, sh_sps_d;
    pps_entry_t       sh_pps_q, sh_pps_d;
    sps_entry_t       sps_tab_q [NUM_SPS];
    pps_entry_t       pps_tab_q [NUM_PPS];
    logic [NUM_SPS-1:0] sps_vld_q;
    logic [NUM_PPS-1:0] pps_vld_q;

    logic parse, fire, mode_u, last_f;
    logic [3:0]  nbits;
    err_t        fe;
    logic        rd_empty, rd_valid, rd_ovf, rd_trunc;
    logic [31:0] v;

    assign parse = (state_q == PARSE_SPS) || (state_q == PARSE_PPS);
    // once s_last is in, a parse state must not swallow the next NAL
    assign s.s_ready = parse ? (rd_empty && !last_q)
                     : (state_q == IDLE || state_q == DRAIN ||
                        state_q == ERR_DRAIN);
    assign fire = s.s_valid && s.s_ready;
    assign busy = (state_q != IDLE);

    exp_golomb_reader #(.MAX_UE_LZ(MAX_UE_LZ)) u_rd (
        .clk(clk), .reset(reset),
        .clr_i(!parse), .en_i(parse),
        .mode_u_i(mode_u), .nbits_i(nbits),
        .byte_i(s.s_data), .load_i(fire && parse),
        .last_seen_i(last_q), .empty_o(rd_empty),
        .field_valid_o(rd_valid), .value_o(v),
        .lz_overflow_o(rd_ovf), .truncated_o(rd_trunc)
    );

    always_comb begin
        mode_u = 1'b0;
        nbits  = 4'd0;
        fe     = ERR_NONE;
        last_f = 1'b0;
        if (state_q == PARSE_SPS) begin
            case (field_q)
                3'd0: if (v >= 32'(NUM_SPS)) fe = ERR_ID;
                3'd1, 3'd4: begin
                    mode_u = 1'b1;
                    nbits  = 4'd8;
                    if (field_q == 3'd4 && v == 32'd0) fe = ERR_RANGE;
                end
                3'd2, 3'd3:
                    if (v == 32'd0 || v > 32'(MAX_WIDTH)) fe = ERR_RANGE;
                3'd5: if (v > 32'(MAX_CHROMA)) fe = ERR_RANGE;
                default: begin
                    if (v > 32'(MAX_BD_M8)) fe = ERR_RANGE;
                    last_f = 1'b1;
                end
            endcase
        end else if (state_q == PARSE_PPS) begin
            case (field_q)
                3'd0: if (v >= 32'(NUM_PPS)) fe = ERR_ID;
                3'd1: if (v >= 32'(NUM_SPS)) fe = ERR_ID;
                3'd2: begin
                    mode_u = 1'b1;
                    nbits  = 4'd6;
                    if (v > 32'(MAX_QP)) fe = ERR_RANGE;
                end
                3'd3: begin
                    mode_u = 1'b1;
                    nbits  = 4'd1;
                    last_f = !v[0];
                end
                default: begin
                    if (v > 32'(MAX_TILE_M1)) fe = ERR_RANGE;
                    last_f = (field_q == 3'd5);
                end
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        field_d  = field_q;
        kind_d   = kind_q;
        last_d   = last_q;
        err_d    = err_q;
        id_d     = id_q;
        sh_sps_d = sh_sps_q;
        sh_pps_d = sh_pps_q;
        if (fire && s.s_last) last_d = 1'b1;
        case (state_q)
            IDLE: if (fire) begin
                last_d  = s.s_last;
                field_d = 3'd0;
                err_d   = ERR_NONE;
                if (s.s_data == NAL_SPS) begin
                    kind_d  = K_SPS;
                    state_d = PARSE_SPS;
                end else if (s.s_data == NAL_PPS) begin
                    kind_d  = K_PPS;
                    state_d = PARSE_PPS;
                end else begin
                    kind_d  = K_NONE;
                    state_d = s.s_last ? COMMIT : DRAIN;
                end
            end
            PARSE_SPS, PARSE_PPS: begin
                if (rd_trunc) begin
                    err_d   = ERR_TRUNC;
                    state_d = ERROR;
                end else if (rd_ovf) begin
                    err_d   = ERR_LZ;
                    state_d = last_q ? ERROR : ERR_DRAIN;
                end else if (rd_valid && fe != ERR_NONE) begin
                    err_d   = fe;
                    state_d = last_q ? ERROR : ERR_DRAIN;
                end else if (rd_valid) begin
                    if (field_q == 3'd0) id_d = v[IDW-1:0];
                    if (state_q == PARSE_SPS) begin
                        case (field_q)
                            3'd1: sh_sps_d.profile = v[7:0];
                            3'd2: sh_sps_d.width   = v[15:0];
                            3'd3: sh_sps_d.height  = v[15:0];
                            3'd4: sh_sps_d.fps     = v[7:0];
                            3'd5: sh_sps_d.chroma  = v[1:0];
                            3'd6: sh_sps_d.bd_m8   = v[2:0];
                            default: ;
                        endcase
                    end else begin
                        case (field_q)
                            3'd1: sh_pps_d.sps_id = v[7:0];
                            3'd2: sh_pps_d.qp     = v[5:0];
                            3'd3: begin
                                sh_pps_d.tiles = v[0];
                                sh_pps_d.cols  = 4'd1;
                                sh_pps_d.rows  = 4'd1;
                            end
                            3'd4: sh_pps_d.cols = v[3:0] + 4'd1;
                            3'd5: sh_pps_d.rows = v[3:0] + 4'd1;
                            default: ;
                        endcase
                    end
                    if (last_f) state_d = last_q ? COMMIT : DRAIN;
                    else field_d = field_q + 3'd1;
                end
            end
            DRAIN:     if (fire && s.s_last) state_d = COMMIT;
            ERR_DRAIN: if (fire && s.s_last) state_d = ERROR;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            field_q   <= '0;
            kind_q    <= K_NONE;
            last_q    <= 1'b0;
            err_q     <= ERR_NONE;
            id_q      <= '0;
            sh_sps_q  <= '0;
            sh_pps_q  <= '0;
            sps_vld_q <= '0;
            pps_vld_q <= '0;
            for (int i = 0; i < NUM_SPS; i++) sps_tab_q[i] <= '0;
            for (int i = 0; i < NUM_PPS; i++) pps_tab_q[i] <= '0;
            nal_done  <= 1'b0;
            nal_error <= 1'b0;
            err_code  <= '0;
        end else begin
            state_q   <= state_d;
            field_q   <= field_d;
            kind_q    <= kind_d;
            last_q    <= last_d;
            err_q     <= err_d;
            id_q      <= id_d;
            sh_sps_q  <= sh_sps_d;
            sh_pps_q  <= sh_pps_d;
            nal_done  <= (state_q == COMMIT) || (state_q == ERROR);
            nal_error <= (state_q == ERROR);
            if (state_q == ERROR) err_code <= err_q;
            if (state_q == COMMIT) begin
                err_code <= ERR_NONE;
                if (kind_q == K_SPS) begin
                    sps_tab_q[id_q[SIDW-1:0]] <= sh_sps_q;
                    sps_vld_q[id_q[SIDW-1:0]] <= 1'b1;
                end else if (kind_q == K_PPS) begin
                    pps_tab_q[id_q[PIDW-1:0]] <= sh_pps_q;
                    pps_vld_q[id_q[PIDW-1:0]] <= 1'b1;
                end
            end
        end
    end

    pps_entry_t     pe;
    sps_entry_t     se;
    logic [SIDW-1:0] sid;
    logic           act_ok;

    // tables are read before this cycle's commit lands
    always_comb begin
        pe     = pps_tab_q[act_pps_id];
        sid    = pe.sps_id[SIDW-1:0];
        se     = sps_tab_q[sid];
        act_ok = pps_vld_q[act_pps_id] && sps_vld_q[sid] &&
                 (pe.sps_id < 8'(NUM_SPS));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_ack       <= 1'b0;
            act_error     <= 1'b0;
            profile       <= '0;
            width         <= '0;
            height        <= '0;
            fps           <= '0;
            chroma_format <= '0;
            bit_depth     <= '0;
            qp            <= '0;
            tiles_enabled <= 1'b0;
            tile_cols     <= '0;
            tile_rows     <= '0;
        end else begin
            act_ack   <= act_req && act_ok;
            act_error <= act_req && !act_ok;
            if (act_req && act_ok) begin
                profile       <= se.profile;
                width         <= se.width;
                height        <= se.height;
                fps           <= se.fps;
                chroma_format <= se.chroma;
                bit_depth     <= 4'd8 + {1'b0, se.bd_m8};
                qp            <= pe.qp;
                tiles_enabled <= pe.tiles;
                tile_cols     <= pe.cols;
                tile_rows     <= pe.rows;
            end
        end
    end
endmodule
